// File: rtl/tcb_lib_memory.sv
// TCB slave memory: byte-lane writes, aligned word reads, optional wait
// states before rdy and a one- or two-stage registered response path.
`timescale 1ns/1ps

module tcb_lib_memory #(
   parameter int unsigned ABW  = 32,
   parameter int unsigned DBW  = 32,
   parameter int unsigned SLW  = 8,
   parameter int unsigned DLY  = 1,
   parameter int unsigned SIZ  = 256,
   parameter int unsigned WAIT = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 vld,
   output logic                 rdy,
   input  logic                 lck,
   input  logic                 inc,
   input  logic                 rpt,
   input  logic                 wen,
   input  logic [ABW-1:0]       adr,
   input  logic [DBW/SLW-1:0]   ben,
   input  logic [DBW-1:0]       wdt,
   output logic [DBW-1:0]       rdt,
   output logic                 err
);

   localparam int unsigned BEW = DBW / SLW;
   localparam int unsigned ALW = $clog2(BEW);
   localparam int unsigned IDW = ABW - ALW;
   localparam int unsigned MAW = (SIZ > 1) ? $clog2(SIZ) : 1;
   localparam logic [3:0]  WAIT_CNT = 4'(WAIT);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCEPT} state_t;

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             trn;
   logic [IDW-1:0]   idx;
   logic [MAW-1:0]   mem_adr;
   logic             req_err;
   logic             unused_hints;

   logic [DBW-1:0]   mem [SIZ];

   logic             s1_vld_q;
   logic             s1_err_q;
   logic [DBW-1:0]   s1_rdt_q;

   // Arbitration and burst hints carry no meaning for a single-port memory.
   assign unused_hints = lck ^ inc ^ rpt;

   assign idx     = adr[ABW-1:ALW];
   assign mem_adr = idx[MAW-1:0];
   assign req_err = (adr[ALW-1:0] != '0) || (idx >= IDW'(SIZ));

   // rdy is held low by reset; with wait states it waits for the counter.
   assign rdy = rst & ((WAIT == 0) ? 1'b1 : (vld & (cnt_q == WAIT_CNT)));
   assign trn = vld & rdy;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (trn) begin
         cnt_d = '0;
      end else if (vld && !rdy) begin
         cnt_d = cnt_q + 4'd1;
      end
      case (state_q)
         S_IDLE:   if (vld) state_d = (WAIT == 0) ? S_ACCEPT : S_WAIT;
         S_WAIT:   if (cnt_q == WAIT_CNT) state_d = S_ACCEPT;
         S_ACCEPT: if (trn) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: the storage array is deliberately left out of reset so its
   // contents survive rst; trn is already gated by rst, so no reset-edge write.
   always_ff @(posedge clk) begin
      if (trn && wen && !req_err) begin
         for (int b = 0; b < BEW; b++) begin
            if (ben[b]) mem[mem_adr][b*SLW +: SLW] <= wdt[b*SLW +: SLW];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_vld_q <= 1'b0;
         s1_err_q <= 1'b0;
         s1_rdt_q <= '0;
      end else begin
         s1_vld_q <= trn;
         if (trn) begin
            s1_err_q <= req_err;
            s1_rdt_q <= (wen || req_err) ? '0 : mem[mem_adr];
         end
      end
   end

   // rdt keeps the last response; err is qualified so it only pulses with one.
   if (DLY == 2) begin : g_dly2
      logic           s2_vld_q;
      logic           s2_err_q;
      logic [DBW-1:0] s2_rdt_q;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            s2_vld_q <= 1'b0;
            s2_err_q <= 1'b0;
            s2_rdt_q <= '0;
         end else begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
               s2_err_q <= s1_err_q;
               s2_rdt_q <= s1_rdt_q;
            end
         end
      end

      assign rdt = s2_rdt_q;
      assign err = s2_vld_q & s2_err_q;
   end else begin : g_dly1
      assign rdt = s1_rdt_q;
      assign err = s1_vld_q & s1_err_q;
   end

endmodule

// File: tb/tb_tcb_lib_memory.sv
// Bench for tcb_lib_memory: three instances (DLY1/WAIT0, DLY1/WAIT3, DLY2/WAIT0)
// with a reference model feeding per-instance response queues.
`timescale 1ns/1ps

module tb_tcb_lib_memory;

   typedef struct packed {
      logic [31:0] rdt;
      logic        err;
   } rsp_t;

   logic        clk;
   logic        rst;
   logic        vld   [3];
   logic        wen   [3];
   logic [31:0] adr   [3];
   logic [3:0]  ben   [3];
   logic [31:0] wdt   [3];
   logic        rdy_w [3];
   logic [31:0] rdt_w [3];
   logic        err_w [3];

   int          n_chk;
   int          n_err;
   rsp_t        exp_q [3][$];
   logic [31:0] mdl   [3][256];
   bit          t0 [3];
   bit          t1 [3];
   bit          t2 [3];

   tcb_lib_memory #(.DLY(1), .WAIT(0)) u_dut0 (
      .clk(clk), .rst(rst), .vld(vld[0]), .rdy(rdy_w[0]), .lck(1'b0), .inc(1'b0), .rpt(1'b0),
      .wen(wen[0]), .adr(adr[0]), .ben(ben[0]), .wdt(wdt[0]), .rdt(rdt_w[0]), .err(err_w[0]));
   tcb_lib_memory #(.DLY(1), .WAIT(3)) u_dut1 (
      .clk(clk), .rst(rst), .vld(vld[1]), .rdy(rdy_w[1]), .lck(1'b0), .inc(1'b0), .rpt(1'b0),
      .wen(wen[1]), .adr(adr[1]), .ben(ben[1]), .wdt(wdt[1]), .rdt(rdt_w[1]), .err(err_w[1]));
   tcb_lib_memory #(.DLY(2), .WAIT(0)) u_dut2 (
      .clk(clk), .rst(rst), .vld(vld[2]), .rdy(rdy_w[2]), .lck(1'b0), .inc(1'b0), .rpt(1'b0),
      .wen(wen[2]), .adr(adr[2]), .ben(ben[2]), .wdt(wdt[2]), .rdt(rdt_w[2]), .err(err_w[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Sampled mid-cycle: t0 is the transfer about to happen, t1/t2 the ones
   // one and two edges back; a response is due at t1 (DLY=1) or t2 (DLY=2).
   task automatic monitor();
      logic [31:0] a;
      logic        e;
      rsp_t        want;
      rsp_t        got;
      bit          due;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (!rst) begin
               t0[k] = 1'b0;
               t1[k] = 1'b0;
               t2[k] = 1'b0;
               exp_q[k].delete();
            end else begin
               t2[k] = t1[k];
               t1[k] = t0[k];
               t0[k] = vld[k] & rdy_w[k];
               if (t0[k]) begin
                  a = adr[k];
                  e = (a[1:0] != 2'b00) || (a[31:2] >= 30'd256);
                  if (e) begin
                     want = {32'h0, 1'b1};
                  end else if (wen[k]) begin
                     for (int b = 0; b < 4; b++) begin
                        if (ben[k][b]) mdl[k][a[9:2]][8*b +: 8] = wdt[k][8*b +: 8];
                     end
                     want = {32'h0, 1'b0};
                  end else begin
                     want = {mdl[k][a[9:2]], 1'b0};
                  end
                  exp_q[k].push_back(want);
               end
               due = (k == 2) ? t2[k] : t1[k];
               n_chk++;
               if (due) begin
                  if (exp_q[k].size() == 0) begin
                     n_err++;
                     $display("FAIL sb_unexpected[%0d]: response due with empty queue", k);
                  end else begin
                     want = exp_q[k].pop_front();
                     got  = {rdt_w[k], err_w[k]};
                     if (got !== want) begin
                        n_err++;
                        $display("FAIL sb_rsp[%0d]: got rdt=%h err=%b expected rdt=%h err=%b",
                                 k, got.rdt, got.err, want.rdt, want.err);
                     end
                  end
               end else if (err_w[k] !== 1'b0) begin
                  n_err++;
                  $display("FAIL sb_idle_err[%0d]: got err=%b expected 0", k, err_w[k]);
               end
            end
         end
      end
   endtask

   // Issues one request on instance k and returns just after its transfer edge.
   task automatic req(input int k, input logic w, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] d);
      bit done;
      done   = 1'b0;
      vld[k] = 1'b1;
      wen[k] = w;
      adr[k] = a;
      ben[k] = b;
      wdt[k] = d;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (rdy_w[k]) done = 1'b1;
      end
      n_chk++;
      if (!done) begin
         n_err++;
         $display("FAIL req_timeout[%0d]: rdy got 0 expected 1 within 40 cycles", k);
      end
      @(posedge clk);
      #1;
      vld[k] = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         n_chk++;
         if ({rdy_w[k], err_w[k], rdt_w[k]} !== 34'h0) begin
            n_err++;
            $display("FAIL reset_state[%0d]: got rdy=%b err=%b rdt=%h expected all 0",
                     k, rdy_w[k], err_w[k], rdt_w[k]);
         end
      end
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      n_chk++;
      if (rdy_w[0] !== 1'b1) begin
         n_err++;
         $display("FAIL reset_release_rdy: got %b expected 1", rdy_w[0]);
      end
   endtask

   task automatic test_write_read();
      req(0, 1'b1, 32'h10, 4'hF, 32'h11223344);
      req(0, 1'b0, 32'h10, 4'hF, 32'h0);
      n_chk++;
      if (rdt_w[0] !== 32'h11223344 || err_w[0] !== 1'b0) begin
         n_err++;
         $display("FAIL write_read: got rdt=%h err=%b expected 11223344 0", rdt_w[0], err_w[0]);
      end
   endtask

   task automatic test_byte_enables();
      req(0, 1'b1, 32'h10, 4'b0101, 32'hAABBCCDD);
      req(0, 1'b0, 32'h10, 4'hF, 32'h0);
      n_chk++;
      if (rdt_w[0] !== 32'h11BB33DD) begin
         n_err++;
         $display("FAIL byte_enables: got %h expected 11bb33dd", rdt_w[0]);
      end
      req(0, 1'b0, 32'h10, 4'b0000, 32'h0);
      n_chk++;
      if (rdt_w[0] !== 32'h11BB33DD) begin
         n_err++;
         $display("FAIL read_ben_zero: got %h expected 11bb33dd", rdt_w[0]);
      end
   endtask

   task automatic test_errors();
      req(0, 1'b1, 32'h0, 4'hF, 32'h5A5A5A5A);
      req(0, 1'b0, 32'h402, 4'hF, 32'h0);
      n_chk++;
      if (err_w[0] !== 1'b1 || rdt_w[0] !== 32'h0) begin
         n_err++;
         $display("FAIL err_misaligned: got err=%b rdt=%h expected 1 00000000", err_w[0], rdt_w[0]);
      end
      req(0, 1'b1, 32'h400, 4'hF, 32'hFFFFFFFF);
      n_chk++;
      if (err_w[0] !== 1'b1) begin
         n_err++;
         $display("FAIL err_range: got err=%b expected 1", err_w[0]);
      end
      req(0, 1'b1, 32'h12, 4'hF, 32'hFFFFFFFF);
      req(0, 1'b0, 32'h0, 4'hF, 32'h0);
      n_chk++;
      if (rdt_w[0] !== 32'h5A5A5A5A) begin
         n_err++;
         $display("FAIL err_write_kept0: got %h expected 5a5a5a5a", rdt_w[0]);
      end
      req(0, 1'b0, 32'h10, 4'hF, 32'h0);
   endtask

   task automatic chk_rdy1(input string name, input logic want);
      n_chk++;
      if (rdy_w[1] !== want) begin
         n_err++;
         $display("FAIL %s: got rdy=%b expected %b", name, rdy_w[1], want);
      end
   endtask

   task automatic test_wait_states();
      vld[1] = 1'b1;
      wen[1] = 1'b1;
      adr[1] = 32'h20;
      ben[1] = 4'hF;
      wdt[1] = 32'hCAFEF00D;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         chk_rdy1("wait_held", (c == 4) ? 1'b1 : 1'b0);
      end
      @(posedge clk);
      #1;
      wen[1] = 1'b0;
      @(negedge clk);
      chk_rdy1("wait_resume_c0", 1'b0);
      @(negedge clk);
      chk_rdy1("wait_resume_c1", 1'b0);
      @(posedge clk);
      #1;
      vld[1] = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk_rdy1("wait_dropped", 1'b0);
      end
      @(posedge clk);
      #1;
      vld[1] = 1'b1;
      @(negedge clk);
      chk_rdy1("wait_resume_c2", 1'b0);
      @(negedge clk);
      chk_rdy1("wait_resume_c3", 1'b1);
      @(posedge clk);
      #1;
      vld[1] = 1'b0;
      n_chk++;
      if (rdt_w[1] !== 32'hCAFEF00D) begin
         n_err++;
         $display("FAIL wait_read: got %h expected cafef00d", rdt_w[1]);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d [4];
      logic [31:0] want;
      d = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
      for (int i = 0; i < 4; i++) req(2, 1'b1, 32'(4*i), 4'hF, d[i]);
      for (int i = 0; i < 4; i++) begin
         req(2, 1'b0, 32'(4*i), 4'hF, 32'h0);
         want = (i == 0) ? 32'h0 : d[i-1];
         n_chk++;
         if (rdt_w[2] !== want) begin
            n_err++;
            $display("FAIL b2b_read%0d: got %h expected %h", i, rdt_w[2], want);
         end
      end
      @(posedge clk);
      #1;
      n_chk++;
      if (rdt_w[2] !== d[3]) begin
         n_err++;
         $display("FAIL b2b_last: got %h expected %h", rdt_w[2], d[3]);
      end
   endtask

   task automatic test_reset_mid();
      req(2, 1'b0, 32'h4, 4'hF, 32'h0);
      rst = 1'b0;
      #1;
      n_chk++;
      if ({rdy_w[2], err_w[2], rdt_w[2]} !== 34'h0) begin
         n_err++;
         $display("FAIL reset_mid: got rdy=%b err=%b rdt=%h expected all 0",
                  rdy_w[2], err_w[2], rdt_w[2]);
      end
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      req(0, 1'b0, 32'h10, 4'hF, 32'h0);
      n_chk++;
      if (rdt_w[0] !== 32'h11BB33DD) begin
         n_err++;
         $display("FAIL reset_first_edge: got %h expected 11bb33dd", rdt_w[0]);
      end
      @(posedge clk);
      #1;
      n_chk++;
      if (rdt_w[2] !== 32'h0 || err_w[2] !== 1'b0) begin
         n_err++;
         $display("FAIL reset_discard: got rdt=%h err=%b expected 0 0", rdt_w[2], err_w[2]);
      end
      req(2, 1'b0, 32'h4, 4'hF, 32'h0);
      @(posedge clk);
      #1;
      n_chk++;
      if (rdt_w[2] !== 32'hB1B1B1B1) begin
         n_err++;
         $display("FAIL reset_mem_kept: got %h expected b1b1b1b1", rdt_w[2]);
      end
   endtask

   task automatic test_drain();
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         n_chk++;
         if (exp_q[k].size() != 0) begin
            n_err++;
            $display("FAIL drain[%0d]: got %0d outstanding expected 0", k, exp_q[k].size());
         end
      end
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst   = 1'b0;
      for (int k = 0; k < 3; k++) begin
         vld[k] = 1'b0;
         wen[k] = 1'b0;
         adr[k] = 32'h0;
         ben[k] = 4'h0;
         wdt[k] = 32'h0;
      end
      fork
         monitor();
      join_none
      test_reset();
      test_write_read();
      test_byte_enables();
      test_errors();
      test_wait_states();
      test_back_to_back();
      test_reset_mid();
      test_drain();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/tcb_lib_memory.md
TCB_LIB_MEMORY -- requirements
Module: tcb_lib_memory

Interface
REQ-001 Parameters SHALL be as follows.
- ABW, 32: address bus width.
- DBW, 32: data bus width.
- SLW, 8: byte lane width; BEW = DBW/SLW lanes.
- DLY, 1: response delay in cycles; legal values are 1 and 2.
- SIZ, 256: memory depth in DBW-wide words.
- WAIT, 0: wait-state cycles before rdy is asserted; legal range is 0 to 15.

REQ-002 Ports SHALL be as follows.
- clk  in  1  clock.
- rst  in  1  reset.
- vld  in  1  request valid.
- rdy  out  1  request ready.
- lck  in  1  arbitration lock; ignored.
- inc  in  1  incrementing hint; ignored.
- rpt  in  1  repeat hint; ignored.
- wen  in  1  write enable.
- adr  in  ABW  byte address.
- ben  in  BEW  byte enables.
- wdt  in  DBW  write data.
- rdt  out  DBW  read data.
- err  out  1  error response.

REQ-003 The block SHALL have one clock, clk; reset rst SHALL be asynchronous and active-low.

Function
REQ-004 A transfer SHALL occur on a rising clk edge where vld=1 and rdy=1 (trn).
REQ-005 With WAIT=0, rdy SHALL be constant 1 whenever reset is inactive, giving one transfer per cycle.
REQ-006 With WAIT>0, a wait-state counter cnt SHALL control rdy.
- cnt is 4 bits, reset to 0.
- cnt increments on each edge with vld=1 and rdy=0.
- rdy = vld & (cnt==WAIT).
- cnt returns to 0 on trn.
REQ-007 With WAIT>0, cnt SHALL hold its value when vld is deasserted before a transfer.
REQ-008 Address decode SHALL use word index adr[ABW-1:log2(BEW)].
REQ-009 A request SHALL be an error when either:
- the word index is >= SIZ, or
- any of adr[log2(BEW)-1:0] is nonzero (misaligned).
REQ-010 A write transfer with no error SHALL update only the byte lanes with ben[b]=1, at the transfer edge.
REQ-011 An error write SHALL leave the memory unchanged.
REQ-012 A read transfer with no error SHALL return the full word regardless of ben.
REQ-013 A write transfer or an error transfer SHALL return rdt all zeros.
REQ-014 The response for the transfer at edge N SHALL appear on rdt/err during the cycle after edge N+DLY-1.
- DLY=1: registered at the transfer edge.
- DLY=2: passes through one extra register stage.
REQ-015 A read following a write to the same word in the next cycle SHALL return the newly written data.
REQ-016 Back-to-back transfers SHALL produce back-to-back responses with no bubbles and no reordering.
REQ-017 In cycles with no response due, err SHALL be 0 and rdt SHALL hold its last response value.
REQ-018 Wait-state and response state SHALL use states IDLE, WAIT and ACCEPT, with these transitions:
- IDLE to WAIT on vld with WAIT>0.
- WAIT to ACCEPT when cnt==WAIT.
- ACCEPT to IDLE on trn.
- IDLE to ACCEPT directly when WAIT=0.

Reset
REQ-019 While rst=0, the following SHALL hold:
- rdy=0, cnt=0, state IDLE;
- all response pipeline registers cleared;
- rdt=0, err=0.
REQ-020 Memory contents SHALL NOT be reset.
REQ-021 Responses pending when reset asserts SHALL be discarded.
REQ-022 No write SHALL occur on an edge where rst=0.
REQ-023 After rst deasserts, the first transfer SHALL be possible on the first rising edge.

Verification
REQ-024 Write/read, DLY=1, WAIT=0: write 0x11223344 to adr 0x10 with ben=4'hF, then read 0x10 -> rdt=0x11223344, err=0, one cycle after the read edge.
REQ-025 Byte enables: write 0xAABBCCDD with ben=4'b0101 over 0x11223344, then read -> 0x11BB33DD.
REQ-026 Errors:
- read of adr 0x402 (misaligned) -> err=1, rdt=0.
- write of adr 0x400 with SIZ=256 (out of range) -> err=1, memory unchanged.
REQ-027 Wait states, WAIT=3: vld held high -> rdy rises on the 4th cycle and the transfer completes there; vld dropped after 2 cycles then reasserted -> count resumes from 2.
REQ-028 Pipelined reads, DLY=2, WAIT=0: 4 back-to-back reads of 0x0, 0x4, 0x8, 0xC -> 4 consecutive responses in order, starting 2 cycles after the first transfer.
REQ-029 Reset mid-transfer: assert rst during a pending DLY=2 response -> rdt=0, err=0, rdy=0 immediately; memory retains previously written data.
